// File: rtl/wb_copy_master_pkg.sv
// Shared definitions for the Wishbone word-copy initiator: FSM encoding and
// address stepping.
package wb_copy_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Byte-address step between consecutive words; one word spans all byte lanes.
    function automatic int unsigned addr_inc(input int unsigned sel_w);
        return sel_w;
    endfunction

endpackage

// File: rtl/wb_copy_master_if.sv
// Wishbone classic-cycle bus between the copy initiator and its responder.
interface wb_copy_master_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   adr_o;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic                    we_o;
    logic [SELECT_WIDTH-1:0] sel_o;
    logic                    stb_o;
    logic                    cyc_o;
    logic                    ack_i;
    logic                    err_i;

    modport master (
        output adr_o, dat_o, we_o, sel_o, stb_o, cyc_o,
        input  dat_i, ack_i, err_i
    );

    modport slave (
        input  adr_o, dat_o, we_o, sel_o, stb_o, cyc_o,
        output dat_i, ack_i, err_i
    );
endinterface

// File: rtl/wb_copy_master_timeout_cnt.sv
// Strobe-phase watchdog: reloaded when a new strobe phase begins, counts
// down while the phase waits, flags expiry after TIMEOUT waiting cycles.
module wb_copy_master_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       cnt <= '0;
        else if (load)                 cnt <= LOAD_VAL;
        else if (run && cnt != '0)     cnt <= cnt - CW'(1);
    end

    // Zero is reached on the edge that samples the TIMEOUT-th unanswered cycle.
    assign expired = run && (cnt == '0);
endmodule

// File: rtl/wb_copy_master.sv
// Wishbone initiator copying len words from src to dst, one single read then
// one single write per word; reports busy, a done pulse and a sticky error.
module wb_copy_master
    import wb_copy_master_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH    = 16,
    parameter int TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [LEN_WIDTH-1:0]  words_done_o,
    wb_copy_master_if.master      wb
);
    localparam logic [ADDR_WIDTH-1:0]   ADDR_INC = ADDR_WIDTH'(addr_inc(SELECT_WIDTH));
    localparam logic [SELECT_WIDTH-1:0] SEL_ALL  = '1;

    state_e                state, state_n;
    logic [ADDR_WIDTH-1:0] src, dst;
    logic [LEN_WIDTH-1:0]  rem;
    logic                  accept, rd_ack, wr_ack, fail;
    logic                  in_phase, strobe_n, tmo_load, tmo_expired;

    assign in_phase = (state == ST_READ) || (state == ST_WRITE);
    assign strobe_n = (state_n == ST_READ) || (state_n == ST_WRITE);
    assign tmo_load = strobe_n && (state_n != state);

    wb_copy_master_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .load    (tmo_load),
        .run     (in_phase),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Abort and err_i beat a same-cycle ack; ack beats the watchdog.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        rd_ack  = 1'b0;
        wr_ack  = 1'b0;
        fail    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    accept  = 1'b1;
                    state_n = (len_i == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ, ST_WRITE: begin
                if (abort_i || wb.err_i) begin
                    fail    = 1'b1;
                    state_n = ST_DONE;
                end else if (wb.ack_i) begin
                    if (state == ST_READ) begin
                        rd_ack  = 1'b1;
                        state_n = ST_WRITE;
                    end else begin
                        wr_ack  = 1'b1;
                        state_n = (rem == LEN_WIDTH'(1)) ? ST_DONE : ST_READ;
                    end
                end else if (tmo_expired) begin
                    fail    = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src          <= '0;
            dst          <= '0;
            rem          <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            words_done_o <= '0;
            wb.adr_o     <= '0;
            wb.dat_o     <= '0;
            wb.we_o      <= 1'b0;
            wb.sel_o     <= '0;
            wb.stb_o     <= 1'b0;
            wb.cyc_o     <= 1'b0;
        end else begin
            busy_o   <= (state_n != ST_IDLE);
            done_o   <= (state == ST_DONE);
            wb.stb_o <= strobe_n;
            wb.cyc_o <= strobe_n;
            wb.we_o  <= (state_n == ST_WRITE);
            wb.sel_o <= strobe_n ? SEL_ALL : '0;
            if (accept) begin
                src          <= src_addr_i;
                dst          <= dst_addr_i;
                rem          <= len_i;
                error_o      <= 1'b0;
                words_done_o <= '0;
                wb.adr_o     <= src_addr_i;
            end
            // dat_o doubles as the word buffer between read and write.
            if (rd_ack) begin
                wb.dat_o <= wb.dat_i;
                wb.adr_o <= dst;
            end
            if (wr_ack) begin
                words_done_o <= words_done_o + LEN_WIDTH'(1);
                rem          <= rem - LEN_WIDTH'(1);
                src          <= src + ADDR_INC;
                dst          <= dst + ADDR_INC;
                wb.adr_o     <= src + ADDR_INC;
            end
            if (fail) error_o <= 1'b1;
        end
    end
endmodule

// File: doc/wb_copy_master.md
Name: wb_copy_master

Overview:
- Wishbone classic-cycle initiator: copies LEN words from a source byte address to a destination byte address.
- Issues one single-word read, then one single-word write, per word.
- Drives one port of the dual-port block RAM or any other Wishbone responder.
- Started by a control pulse from the CPU-side register block; reports busy, done and error.

Parameters:
ADDR_WIDTH, 32, Wishbone address width in bits (byte address)
DATA_WIDTH, 32, data bus width in bits (8, 16, 32 or 64)
SELECT_WIDTH, DATA_WIDTH/8, byte-select width
LEN_WIDTH, 16, width of word-count input and progress counter
TIMEOUT, 255, max cycles a strobe may wait for ack_i/err_i before abort (>=1)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
start_i  in  1  one-cycle request; sampled only in IDLE
abort_i  in  1  cancel running copy
src_addr_i  in  ADDR_WIDTH  source byte address, latched on accepted start
dst_addr_i  in  ADDR_WIDTH  destination byte address, latched on accepted start
len_i  in  LEN_WIDTH  number of words, latched on accepted start
busy_o  out  1  high from the cycle after accepted start until DONE
done_o  out  1  one-cycle completion pulse
error_o  out  1  sticky error flag; cleared by the next accepted start
words_done_o  out  LEN_WIDTH  words fully written in current/last copy
adr_o  out  ADDR_WIDTH  Wishbone ADR_O
dat_o  out  DATA_WIDTH  Wishbone DAT_O
dat_i  in  DATA_WIDTH  Wishbone DAT_I
we_o  out  1  Wishbone WE_O
sel_o  out  SELECT_WIDTH  Wishbone SEL_O, all ones whenever stb_o=1
stb_o  out  1  Wishbone STB_O
cyc_o  out  1  Wishbone CYC_O, equal to stb_o
ack_i  in  1  Wishbone ACK_I
err_i  in  1  Wishbone ERR_I

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0, including adr_o, dat_o, sel_o and words_done_o; internal counters and registers cleared.
- All outputs are registered.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - start_i=1 and abort_i=0: latch src/dst/len, clear error_o and words_done_o.
  - If len_i=0: go to DONE; no bus cycle is issued.
  - Otherwise: go to READ with cyc/stb=1, we=0, adr=src.
  - start_i together with abort_i is ignored.
- READ: hold cyc/stb/adr until ack_i or err_i is sampled high.
  - On ack: register dat_i into the data buffer; next cycle enter WRITE with stb kept high, we=1, adr=dst, dat_o=buffer.
  - No idle cycle between the read and the write. This is legal against responders that gate on their own registered ack.
- WRITE: on ack:
  - words_done+1; src and dst each advance by SELECT_WIDTH.
  - Addresses wrap modulo 2^ADDR_WIDTH with no error.
  - If remaining count = 0, go to DONE with stb/cyc/we dropped; else go to READ at the new src.
- err_i high in READ or WRITE: drop cyc/stb next cycle, set error_o, go to DONE. If ack_i and err_i are both high, err wins.
- Timeout:
  - The counter resets on each new strobe phase (entry to READ or WRITE) and counts cycles with stb high and no ack/err.
  - Reaching TIMEOUT: terminate the cycle as for err_i.
- abort_i high in READ/WRITE: drop cyc/stb next cycle even mid-cycle, set error_o, go to DONE. A late ack arriving afterwards is ignored.
- DONE: done_o=1 for exactly one cycle, busy_o=0, then return to IDLE.
- start_i in any state other than IDLE is ignored; there is no queueing.
- Latency with a 1-cycle-ack responder: 4 cycles per word; len=N gives done_o 4N+2 cycles after start_i.

Decomposition:
- Shared header wb_defs.vh holds:
  - state encodings (IDLE=0, READ=1, WRITE=2, DONE=3);
  - the Wishbone select-all constant;
  - the address increment derived from SELECT_WIDTH.
- One natural sub-module: wb_timeout_cnt (load on strobe start, decrement, expiry flag). The rest stays in one FSM module.

Test Plan:
- Preload RAM words 0x00..0x03 with 0x11111111..0x44444444; start with src=0x0, dst=0x100, len=4 -> RAM 0x100..0x10C hold the same data; words_done=4; error=0; done pulse 18 cycles after start.
- len=0 -> done pulse 2 cycles after start; cyc_o never asserted; error=0.
- src=0xFFFFFFFC, len=2 -> second read at adr 0x00000000 (wrap); copy completes; error=0.
- Responder asserts err_i on the 2nd write of len=3 -> cyc drops; error=1; words_done=1; done pulse; a following start clears error.
- Responder never acks, TIMEOUT=8 -> stb high exactly 8 cycles, then cyc=0, error=1, done pulse.
- abort_i mid-READ of word 2, and separately async rst mid-WRITE -> abort: cyc=0 next cycle, error=1, words_done=1; rst: all outputs 0 immediately, IDLE after release.
